// File: rtl/averager_reader.sv
// Streams one averaged record out of the averager BRAM over AXI-Stream through a credit-limited 4-entry FIFO.
// Optional macro AVERAGER_READER_NAVG_HEADER_EN prepends one header beat carrying the latched n_avg.
module averager_reader #(
    parameter int FAST_COUNT_WIDTH = 13,
    parameter int SLOW_COUNT_WIDTH = 19,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        start,
    input  logic                        ready,
    input  logic [FAST_COUNT_WIDTH-1:0] count_max,
    input  logic [SLOW_COUNT_WIDTH-1:0] n_avg,
    output logic [FAST_COUNT_WIDTH+1:0] bram_addr,
    output logic                        bram_en,
    input  logic [DATA_WIDTH-1:0]       bram_rddata,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);
    localparam int RD_LAT = 2;

    typedef enum logic [1:0] {IDLE, WAIT_READY, READ, DRAIN} state_t;
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                      state, state_nxt;
    logic [FAST_COUNT_WIDTH-1:0] index, cm_q;
    logic [RD_LAT:1]             vld_q, last_q;
    logic [RD_LAT:0]             vld_pipe, last_pipe;
    entry_t                      fifo_mem [4];
    entry_t                      push_entry, head;
    logic [1:0]                  wr_ptr, rd_ptr;
    logic [2:0]                  fifo_count, pending;
    logic                        start_rec, issue_last, hdr_push, push, pop, last_sent, fin;

    assign start_rec  = (state == WAIT_READY) && ready;
    assign issue_last = (index == cm_q);
    assign vld_pipe   = {vld_q, bram_en};
    assign last_pipe  = {last_q, issue_last};

    // Every outstanding read already owns a FIFO slot, so the FIFO can never overflow.
    assign pending = {2'b00, vld_q[1]} + {2'b00, vld_q[2]} + fifo_count;
    assign fin     = (vld_q == '0) && (fifo_count == 3'd0) && last_sent;

`ifdef AVERAGER_READER_NAVG_HEADER_EN
    // The header FIFO entry is the latched copy of n_avg.
    assign hdr_push = start_rec;
`else
    logic unused_navg;
    assign hdr_push    = 1'b0;
    assign unused_navg = ^n_avg;
`endif

    assign push       = vld_pipe[RD_LAT] | hdr_push;
    assign push_entry = hdr_push ? '{last: 1'b0, data: DATA_WIDTH'(n_avg)}
                                 : '{last: last_pipe[RD_LAT], data: bram_rddata};
    assign head       = fifo_mem[rd_ptr];

    assign m_axis_tvalid = (fifo_count != 3'd0);
    assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
    assign m_axis_tlast  = m_axis_tvalid & head.last;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign bram_addr     = bram_en ? {index, 2'b00} : '0;

    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start)                  state_nxt = WAIT_READY;
            WAIT_READY: if (ready)                  state_nxt = READ;
            READ:       if (bram_en && issue_last)  state_nxt = DRAIN;
            DRAIN:      if (fin)                    state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bram_en = 1'b0;
        done    = 1'b0;
        busy    = (state != IDLE);
        case (state)
            READ:    bram_en = (pending < 3'd4);
            DRAIN:   done    = fin;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            index      <= '0;
            cm_q       <= '0;
            vld_q      <= '0;
            last_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            last_sent  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            vld_q  <= vld_pipe[RD_LAT-1:0];
            last_q <= last_pipe[RD_LAT-1:0];
            // Index parks on count_max after the final issue so it can never wrap.
            if (start_rec) begin
                index     <= '0;
                cm_q      <= count_max;
                last_sent <= 1'b0;
            end else if (bram_en && !issue_last) begin
                index <= index + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (head.last) last_sent <= 1'b1;
            end
            fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};
            if (state == IDLE && start)
                overrun <= 1'b0;
            else if ((state == READ || state == DRAIN) && !ready)
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

endmodule

// File: tb/tb_averager_reader.sv
// Scoreboard bench for averager_reader: BRAM model with 2-cycle read latency, expected beats queued at start.
// Honours AVERAGER_READER_NAVG_HEADER_EN by expecting the n_avg header beat.
module tb_averager_reader;
    localparam int FW = 13;
    localparam int SW = 19;
    localparam int DW = 32;
`ifdef AVERAGER_READER_NAVG_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct {
        logic          hdr;
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0, srst = 1'b1, start = 1'b0, ready = 1'b0, m_axis_tready = 1'b1;
    logic [FW-1:0] count_max = '0;
    logic [SW-1:0] n_avg = '0;
    logic [FW+1:0] bram_addr;
    logic          bram_en, m_axis_tvalid, m_axis_tlast, busy, done, overrun;
    logic [DW-1:0] bram_rddata, m_axis_tdata;

    logic [DW-1:0] mem [64];
    logic          p1_en = 1'b0, p2_en = 1'b0;
    logic [5:0]    p1_a = '0, p2_a = '0;

    exp_t exp_q[$];
    int checks = 0, failures = 0;
    int cyc = 0, beats, data_beats, en_cnt, done_cnt, gap_cnt, stalls;
    int first_en_cyc, first_data_cyc, last_cyc, done_cyc;

    always #5 clk = ~clk;

    averager_reader dut (
        .clk(clk), .srst(srst), .start(start), .ready(ready),
        .count_max(count_max), .n_avg(n_avg),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_rddata(bram_rddata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .overrun(overrun)
    );

    // BRAM: data valid exactly two cycles after bram_en, garbage otherwise.
    always @(posedge clk) begin
        p1_en <= bram_en;
        p1_a  <= bram_addr[7:2];
        p2_en <= p1_en;
        p2_a  <= p1_a;
    end
    assign bram_rddata = p2_en ? mem[p2_a] : 32'hDEAD_BEEF;

    task automatic monitor();
        exp_t          e;
        logic          prev_stall = 1'b0, prev_last = 1'b0;
        logic [DW-1:0] prev_data = '0;
        bit            in_rec = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bram_en) begin
                if (en_cnt == 0) first_en_cyc = cyc;
                en_cnt++;
                checks++;
                if (bram_addr[1:0] !== 2'b00 || bram_addr[FW+1:8] !== '0) begin
                    failures++;
                    $display("FAIL bram_addr got=%h required=word-aligned index<64", bram_addr);
                end
            end
            if (prev_stall) begin
                stalls++;
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    failures++;
                    $display("FAIL stall_stable got v=%0b d=%h l=%0b required v=1 d=%h l=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got d=%h l=%0b required none", m_axis_tdata, m_axis_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== {e.last, e.data}) begin
                        failures++;
                        $display("FAIL beat got l=%0b d=%h required l=%0b d=%h",
                                 m_axis_tlast, m_axis_tdata, e.last, e.data);
                    end
                    if (!e.hdr) begin
                        if (data_beats == 0) first_data_cyc = cyc;
                        data_beats++;
                        in_rec = !m_axis_tlast;
                    end
                end
                if (m_axis_tlast) last_cyc = cyc;
                beats++;
            end else if (in_rec) begin
                gap_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (srst) begin
                prev_stall = 1'b0;
                in_rec     = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        beats = 0; data_beats = 0; en_cnt = 0; done_cnt = 0; gap_cnt = 0; stalls = 0;
        first_en_cyc = 0; first_data_cyc = 0; last_cyc = 0; done_cyc = 0;
    endtask

    task automatic do_start(input int cm, input int na);
        exp_t e;
        clear_stats();
`ifdef AVERAGER_READER_NAVG_HEADER_EN
        e.hdr = 1'b1; e.last = 1'b0; e.data = DW'(na);
        exp_q.push_back(e);
`endif
        for (int i = 0; i <= cm; i++) begin
            e.hdr = 1'b0; e.last = (i == cm); e.data = mem[i];
            exp_q.push_back(e);
        end
        count_max = FW'(cm);
        n_avg     = SW'(na);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rnd) m_axis_tready = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (done) ok = 1'b1;
            tick();
            if (ok) break;
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== '0) begin
            failures++;
            $display("FAIL reset_stream got v=%0b l=%0b d=%h required 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        checks++;
        if ({bram_en, bram_addr} !== '0) begin
            failures++;
            $display("FAIL reset_bram got en=%0b addr=%h required 0", bram_en, bram_addr);
        end
        checks++;
        if ({busy, done, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status got busy=%0b done=%0b ovr=%0b required 0", busy, done, overrun);
        end
        tick();
        srst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        ready = 1'b1;
        do_start(7, 100);
        tick(); tick();
        count_max = FW'(3);
        n_avg     = SW'(5);
        wait_done(200, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got no done required done"); end
        checks++; if (data_beats != 8) begin failures++; $display("FAIL basic_beats got=%0d required=8", data_beats); end
        checks++; if (beats != 8 + HDR) begin failures++; $display("FAIL basic_total got=%0d required=%0d", beats, 8 + HDR); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_missing got=%0d required=0", exp_q.size()); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_cnt got=%0d required=1", done_cnt); end
        checks++; if (done_cyc - last_cyc != 1) begin failures++; $display("FAIL basic_done_lag got=%0d required=1", done_cyc - last_cyc); end
        checks++; if (gap_cnt != 0) begin failures++; $display("FAIL basic_gaps got=%0d required=0", gap_cnt); end
        checks++; if (first_data_cyc - first_en_cyc != 3) begin failures++; $display("FAIL basic_latency got=%0d required=3", first_data_cyc - first_en_cyc); end
    endtask

    task automatic test_stall();
        bit ok;
        do_start(15, 7);
        wait_done(800, 1'b1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got no done required done"); end
        checks++; if (data_beats != 16) begin failures++; $display("FAIL stall_beats got=%0d required=16", data_beats); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stall_missing got=%0d required=0", exp_q.size()); end
        checks++; if (stalls == 0) begin failures++; $display("FAIL stall_seen got=0 required>0"); end
    endtask

    task automatic test_wait_ready();
        bit ok;
        ready = 1'b0;
        do_start(5, 9);
        for (int i = 0; i < 20; i++) tick();
        checks++; if (en_cnt != 0) begin failures++; $display("FAIL wait_en got=%0d required=0", en_cnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wait_busy got=%0b required=1", busy); end
        ready = 1'b1;
        wait_done(200, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wait_timeout got no done required done"); end
        checks++; if (data_beats != 6) begin failures++; $display("FAIL wait_beats got=%0d required=6", data_beats); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wait_missing got=%0d required=0", exp_q.size()); end
        checks++; if (first_data_cyc - first_en_cyc != 3) begin failures++; $display("FAIL wait_latency got=%0d required=3", first_data_cyc - first_en_cyc); end
    endtask

    task automatic test_single();
        bit ok;
        do_start(0, 1);
        wait_done(100, 1'b0, ok);
        tick(); tick(); tick();
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got no done required done"); end
        checks++; if (data_beats != 1) begin failures++; $display("FAIL single_beats got=%0d required=1", data_beats); end
        checks++; if (beats != 1 + HDR) begin failures++; $display("FAIL single_total got=%0d required=%0d", beats, 1 + HDR); end
        checks++; if (en_cnt != 1) begin failures++; $display("FAIL single_reads got=%0d required=1", en_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL single_done_cnt got=%0d required=1", done_cnt); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_missing got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit = 1'b0;
        do_start(31, 3);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (data_beats >= 5) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin failures++; $display("FAIL rmid_progress got=%0d required>=5", data_beats); end
        srst = 1'b1;
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || bram_en !== 1'b0) begin
            failures++;
            $display("FAIL rmid_flush got v=%0b busy=%0b en=%0b required 0", m_axis_tvalid, busy, bram_en);
        end
        srst = 1'b0;
        exp_q.delete();
        clear_stats();
        for (int i = 0; i < 6; i++) tick();
        checks++; if (beats != 0 || en_cnt != 0) begin failures++; $display("FAIL rmid_stale got beats=%0d reads=%0d required 0", beats, en_cnt); end
        do_start(31, 3);
        wait_done(400, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got no done required done"); end
        checks++; if (data_beats != 32) begin failures++; $display("FAIL rmid_beats got=%0d required=32", data_beats); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_missing got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        bit ok;
        ready = 1'b1;
        do_start(7, 50);
        for (int i = 0; i < 50; i++) begin
            if (en_cnt >= 4) break;
            tick();
        end
        ready = 1'b0;
        wait_done(200, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovr_timeout got no done required done"); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%0b required=1", overrun); end
        checks++; if (data_beats != 8) begin failures++; $display("FAIL ovr_beats got=%0d required=8", data_beats); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ovr_missing got=%0d required=0", exp_q.size()); end
        ready = 1'b1;
        do_start(7, 50);
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b required=0", overrun); end
        wait_done(200, 1'b0, ok);
        checks++; if (!ok || overrun !== 1'b0) begin failures++; $display("FAIL ovr_clean got ok=%0b ovr=%0b required ok=1 ovr=0", ok, overrun); end
        checks++; if (data_beats != 8) begin failures++; $display("FAIL ovr_beats2 got=%0d required=8", data_beats); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {8'(i + 1), 24'($urandom)};
        clear_stats();
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_stall();
        test_wait_ready();
        test_single();
        test_reset_mid();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
